// File: rtl/sign_mag_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Converts an unsigned magnitude and carries the original sign alongside the digits.
module sign_mag_bcd_converter #(
    parameter int DW     = 8,
    parameter int DIGITS = 3,
    parameter int CW     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DW-1:0]         mag_in,
    input  logic                  sign_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + DW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] sr;
    logic [SW-1:0] sr_adj;
    logic [SW-1:0] sr_shift;
    logic [CW-1:0] count;
    logic          sign_q;
    logic          last_shift;

    assign last_shift = (count == CW'(DW - 1));

    // Add-3 on every scratch digit that would overflow past 9 once doubled.
    always_comb begin
        sr_adj = sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (sr[DW + 4*d +: 4] >= 4'd5) begin
                sr_adj[DW + 4*d +: 4] = sr[DW + 4*d +: 4] + 4'd3;
            end
        end
        sr_shift = sr_adj << 1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr       <= '0;
            count    <= '0;
            sign_q   <= 1'b0;
            bcd_out  <= '0;
            sign_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sr     <= {{BW{1'b0}}, mag_in};
                        count  <= '0;
                        // A zero magnitude never carries a minus sign.
                        sign_q <= sign_in & (|mag_in);
                    end
                end
                SHIFT: begin
                    sr    <= sr_shift;
                    count <= count + CW'(1);
                    if (last_shift) begin
                        bcd_out  <= sr_shift[SW-1 -: BW];
                        sign_out <= sign_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_sign_mag_bcd_converter.sv
// Directed bench for sign_mag_bcd_converter: vector table, start-ignore,
// reset abort and back-to-back sweep over every 8-bit magnitude.
module tb_sign_mag_bcd_converter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  mag_in;
    logic        sign_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;
    logic        sign_out;

    int total;
    int bad;
    int cyc;

    logic [11:0] exp_q[$];

    typedef struct {
        logic [7:0]  mag;
        logic        sgn;
        logic [11:0] exp_bcd;
        logic        exp_sign;
    } vec_t;

    vec_t vecs[10];

    sign_mag_bcd_converter #(.DW(8), .DIGITS(3), .CW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mag_in   (mag_in),
        .sign_in  (sign_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .sign_out (sign_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    task automatic do_conv(input logic [7:0] m, input logic s,
                           input logic [11:0] eb, input logic es, input string name);
        int lat;
        @(negedge clk);
        start = 1'b1; mag_in = m; sign_in = s;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs after the capture edge; result must not change.
        mag_in = 8'($urandom_range(0, 255));
        sign_in = 1'($urandom_range(0, 1));
        check({name, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        check({name, "_latency"}, lat, 8);
        check({name, "_bcd"}, 32'(bcd_out), 32'(eb));
        check({name, "_sign"}, 32'(sign_out), 32'(es));
        @(posedge clk); #1;
        check({name, "_done_fall"}, 32'(done), 32'd0);
        check({name, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int pulses;
        int prev_cyc;
        int v;
        logic [11:0] e;

        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; mag_in = '0; sign_in = 1'b0;

        vecs[0] = '{8'd0,   1'b1, 12'h000, 1'b0};
        vecs[1] = '{8'd255, 1'b0, 12'h255, 1'b0};
        vecs[2] = '{8'd128, 1'b1, 12'h128, 1'b1};
        vecs[3] = '{8'd99,  1'b0, 12'h099, 1'b0};
        vecs[4] = '{8'd1,   1'b1, 12'h001, 1'b1};
        vecs[5] = '{8'd9,   1'b0, 12'h009, 1'b0};
        vecs[6] = '{8'd10,  1'b1, 12'h010, 1'b1};
        vecs[7] = '{8'd100, 1'b1, 12'h100, 1'b1};
        vecs[8] = '{8'd199, 1'b0, 12'h199, 1'b0};
        vecs[9] = '{8'd90,  1'b0, 12'h090, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd", 32'(bcd_out), 32'd0);
        check("reset_sign", 32'(sign_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_conv(vecs[i].mag, vecs[i].sgn, vecs[i].exp_bcd, vecs[i].exp_sign,
                    $sformatf("vec%0d", i));
        end

        // Start pulses during SHIFT and DONE must be ignored.
        @(negedge clk);
        start = 1'b1; mag_in = 8'd37; sign_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; mag_in = 8'd200;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                break;
            end
        end
        check("ignore_first_done", pulses, 1);
        start = 1'b1; mag_in = 8'd200;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("ignore_pulse_count", pulses, 1);
        check("ignore_bcd", 32'(bcd_out), 32'h037);
        check("ignore_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-conversion aborts without a done pulse.
        @(negedge clk);
        start = 1'b1; mag_in = 8'd173; sign_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'd0);
        check("abort_sign", 32'(sign_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        do_conv(8'd173, 1'b0, 12'h173, 1'b0, "after_abort");

        // Back-to-back sweep with start held high.
        @(negedge clk);
        v = 0;
        start = 1'b1; mag_in = 8'(v); sign_in = 1'b0;
        exp_q.push_back(to_bcd(v));
        prev_cyc = -1;
        for (int k = 0; k < 256; k++) begin
            pulses = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (done) begin
                    pulses = 1;
                    break;
                end
            end
            if (pulses == 0) begin
                check("b2b_timeout", 32'd0, 32'd1);
                break;
            end
            e = exp_q.pop_front();
            check($sformatf("b2b_bcd_%0d", v), 32'(bcd_out), 32'(e));
            check($sformatf("b2b_sign_%0d", v), 32'(sign_out), 32'((v % 2 == 1) ? 1 : 0));
            if (prev_cyc >= 0) check($sformatf("b2b_spacing_%0d", v), cyc - prev_cyc, 10);
            prev_cyc = cyc;
            if (k < 255) begin
                v = v + 1;
                mag_in = 8'(v);
                sign_in = 1'(v % 2);
                exp_q.push_back(to_bcd(v));
            end else begin
                start = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check("final_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
